// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: instruction memory, EX redirect and
// hazard inputs, IF/ID register outputs and the ID/EX bubble.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc_out;
    logic [31:0]      instr_in;
    logic             imem_ready;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_rt;
    logic             branch_taken_EX;
    logic [31:0]      branch_target_EX;
    logic             jump_EX;
    logic [31:0]      jump_target_EX;
    logic [31:0]      instr_ID;
    logic [31:0]      pc4_ID;
    logic             valid_ID;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output pc_out,
        output instr_ID,
        output pc4_ID,
        output valid_ID,
        output id_ex_bubble,
        output stall_cycles,
        input  instr_in,
        input  imem_ready,
        input  ID_EX_MemRead,
        input  ID_EX_rt,
        input  branch_taken_EX,
        input  branch_target_EX,
        input  jump_EX,
        input  jump_target_EX
    );

    modport slave (
        input  pc_out,
        input  instr_ID,
        input  pc4_ID,
        input  valid_ID,
        input  id_ex_bubble,
        input  stall_cycles,
        output instr_in,
        output imem_ready,
        output ID_EX_MemRead,
        output ID_EX_rt,
        output branch_taken_EX,
        output branch_target_EX,
        output jump_EX,
        output jump_target_EX
    );
endinterface

// File: rtl/if_id_stage.sv
// PC register, IF/ID pipeline register, load-use detection and
// EX redirect for the 5-stage MIPS front end.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input logic            clock,
    input logic            reset,
    if_id_stage_if.master  bus
);
    logic [31:0]      pc;
    logic [31:0]      pc4;
    logic [31:0]      instr;
    logic [31:0]      pc4_q;
    logic             valid;
    logic [CNT_W-1:0] cnt;

    logic        redirect;
    logic [31:0] target;
    logic        load_use;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        stall;

    assign pc4      = pc + 32'd4;
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign redirect = bus.branch_taken_EX | bus.jump_EX;
    assign target   = bus.branch_taken_EX ? bus.branch_target_EX
                                          : bus.jump_target_EX;

    assign load_use = valid & bus.ID_EX_MemRead
                    & (bus.ID_EX_rt != 5'd0)
                    & ((bus.ID_EX_rt == rs) | (bus.ID_EX_rt == rt));

    // Memory wait and load-use both cost a cycle; redirect overrides both.
    assign stall = (load_use | ~bus.imem_ready) & ~redirect;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            instr <= 32'd0;
            pc4_q <= 32'd0;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            if (redirect) begin
                pc    <= target;
                instr <= 32'd0;
                valid <= 1'b0;
            end else if (load_use) begin
                pc    <= pc;
            end else if (!bus.imem_ready) begin
                instr <= 32'd0;
                valid <= 1'b0;
            end else begin
                instr <= bus.instr_in;
                pc4_q <= pc4;
                valid <= 1'b1;
                pc    <= pc4;
            end
            if (stall && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.pc_out       = pc;
    assign bus.instr_ID     = instr;
    assign bus.pc4_ID       = pc4_q;
    assign bus.valid_ID     = valid;
    assign bus.id_ex_bubble = redirect | load_use | ~valid;
    assign bus.stall_cycles = cnt;
endmodule
